// File: rtl/instr_encoder_loader.sv
// rtl/instr_encoder_loader.sv - packs field tuples into instruction words and writes them into imem (option: INSTR_ENC_CHECKSUM_EN)
module instr_encoder_loader #(
   parameter int DBITS     = 32,
   parameter int OPBITS    = 8,
   parameter int REGBITS   = 4,
   parameter int IMMBITS   = 16,
   parameter int ADDRBITS  = 10,
   parameter int MAX_WORDS = 1024
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic                in_last,
   input  logic [OPBITS-1:0]   opcode,
   input  logic [REGBITS-1:0]  rd,
   input  logic [REGBITS-1:0]  rs1,
   input  logic [REGBITS-1:0]  rs2,
   input  logic [IMMBITS-1:0]  imm,
   output logic                wr_valid,
   input  logic                wr_ready,
   output logic [ADDRBITS-1:0] wr_addr,
   output logic [DBITS-1:0]    wr_data,
   output logic                busy,
   output logic                done,
   output logic [ADDRBITS:0]   words_written
`ifdef INSTR_ENC_CHECKSUM_EN
   ,output logic [DBITS-1:0]   checksum
`endif
);

   // bit positions of the two register slots below the opcode
   localparam int LP_F1 = DBITS - OPBITS - 1;
   localparam int LP_F2 = LP_F1 - REGBITS;
   localparam logic [ADDRBITS:0] LP_MAX = (ADDRBITS+1)'(MAX_WORDS);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACCEPT,
      S_HOLD,
      S_DONE
   } state_t;

   state_t              r_state;
   logic                r_in_ready;
   logic                r_wr_valid;
   logic                r_busy;
   logic                r_done;
   logic                r_last;
   logic [ADDRBITS-1:0] r_addr;
   logic [DBITS-1:0]    r_wr_data;
   logic [ADDRBITS:0]   r_words;
   logic [DBITS-1:0]    w_enc;
   logic [ADDRBITS:0]   w_words_nxt;
   logic                w_finish;
`ifdef INSTR_ENC_CHECKSUM_EN
   logic [DBITS-1:0]    r_checksum;
`endif

   // field placement selected by the opcode class in the top two opcode bits
   always_comb begin
      w_enc = '0;
      w_enc[DBITS-1 -: OPBITS] = opcode;
      case (opcode[OPBITS-1 -: 2])
         2'b00: begin
            w_enc[LP_F1 -: REGBITS]   = rd;
            w_enc[LP_F2 -: REGBITS]   = rs1;
            w_enc[IMMBITS-1 -: REGBITS] = rs2;
         end
         2'b11: begin
            w_enc[LP_F1 -: REGBITS] = rs1;
            w_enc[LP_F2 -: REGBITS] = rs2;
            w_enc[IMMBITS-1:0]      = imm;
         end
         default: begin
            w_enc[LP_F1 -: REGBITS] = rd;
            w_enc[LP_F2 -: REGBITS] = rs1;
            w_enc[IMMBITS-1:0]      = imm;
         end
      endcase
   end

   // session ends on the tagged last word or when the word budget is used up
   always_comb begin
      w_words_nxt = r_words + 1'b1;
      w_finish    = r_last || (w_words_nxt == LP_MAX);
   end

   // load-session FSM; every output is a register so handshakes see no comb paths
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_in_ready <= 1'b0;
         r_wr_valid <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_last     <= 1'b0;
         r_addr     <= '0;
         r_wr_data  <= '0;
         r_words    <= '0;
`ifdef INSTR_ENC_CHECKSUM_EN
         r_checksum <= '0;
`endif
      end else begin
         case (r_state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  r_state    <= S_ACCEPT;
                  r_in_ready <= 1'b1;
                  r_busy     <= 1'b1;
                  r_done     <= 1'b0;
                  r_addr     <= '0;
                  r_words    <= '0;
`ifdef INSTR_ENC_CHECKSUM_EN
                  r_checksum <= '0;
`endif
               end
            end
            S_ACCEPT: begin
               if (in_valid) begin
                  r_state    <= S_HOLD;
                  r_in_ready <= 1'b0;
                  r_wr_valid <= 1'b1;
                  r_wr_data  <= w_enc;
                  r_last     <= in_last;
               end
            end
            S_HOLD: begin
               if (wr_ready) begin
                  r_words    <= w_words_nxt;
                  r_wr_valid <= 1'b0;
`ifdef INSTR_ENC_CHECKSUM_EN
                  r_checksum <= r_checksum ^ r_wr_data;
`endif
                  if (w_finish) begin
                     // address stays on the final word so it never passes MAX_WORDS-1
                     r_state <= S_DONE;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                  end else begin
                     r_state    <= S_ACCEPT;
                     r_in_ready <= 1'b1;
                     r_addr     <= r_addr + 1'b1;
                  end
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign in_ready      = r_in_ready;
   assign wr_valid      = r_wr_valid;
   assign wr_addr       = r_addr;
   assign wr_data       = r_wr_data;
   assign busy          = r_busy;
   assign done          = r_done;
   assign words_written = r_words;
`ifdef INSTR_ENC_CHECKSUM_EN
   assign checksum      = r_checksum;
`endif

endmodule

// File: tb/tb_instr_encoder_loader.sv
// tb/tb_instr_encoder_loader.sv - directed bench for instr_encoder_loader
`timescale 1ns/1ps
module tb_instr_encoder_loader;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        start4 = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_last = 1'b0;
   logic [7:0]  opcode = '0;
   logic [3:0]  rd = '0, rs1 = '0, rs2 = '0;
   logic [15:0] imm = '0;
   logic        wr_ready = 1'b0;

   logic        in_ready, wr_valid, busy, done;
   logic [9:0]  wr_addr;
   logic [31:0] wr_data;
   logic [10:0] words_written;
   logic        in_ready4, wr_valid4, busy4, done4;
   logic [9:0]  wr_addr4;
   logic [31:0] wr_data4;
   logic [10:0] words_written4;
`ifdef INSTR_ENC_CHECKSUM_EN
   logic [31:0] checksum, checksum4;
`endif

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   instr_encoder_loader u_dut (
      .clk(clk), .reset(reset), .start(start),
      .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
      .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
      .busy(busy), .done(done), .words_written(words_written)
`ifdef INSTR_ENC_CHECKSUM_EN
      ,.checksum(checksum)
`endif
   );

   instr_encoder_loader #(.MAX_WORDS(4)) u_dut4 (
      .clk(clk), .reset(reset), .start(start4),
      .in_valid(in_valid), .in_ready(in_ready4), .in_last(in_last),
      .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
      .wr_valid(wr_valid4), .wr_ready(wr_ready), .wr_addr(wr_addr4), .wr_data(wr_data4),
      .busy(busy4), .done(done4), .words_written(words_written4)
`ifdef INSTR_ENC_CHECKSUM_EN
      ,.checksum(checksum4)
`endif
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tuple(input logic [7:0] op, input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] c, input logic [15:0] i, input logic last);
      opcode = op; rd = a; rs1 = b; rs2 = c; imm = i; in_last = last;
   endtask

   task automatic chk_idle_zero(input string tag);
      chk({tag, "_in_ready"}, 64'(in_ready), 64'd0);
      chk({tag, "_wr_valid"}, 64'(wr_valid), 64'd0);
      chk({tag, "_busy"}, 64'(busy), 64'd0);
      chk({tag, "_done"}, 64'(done), 64'd0);
      chk({tag, "_wr_addr"}, 64'(wr_addr), 64'd0);
      chk({tag, "_wr_data"}, 64'(wr_data), 64'd0);
      chk({tag, "_words"}, 64'(words_written), 64'd0);
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk_idle_zero("rst");
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   initial begin
      int a;
      int n_wr;
      logic prev_rdy;

      // reset state
      repeat (2) @(negedge clk);
      chk_idle_zero("por");
      reset = 1'b0;

      // single R-type word, imm ignored
      pulse_start();
      chk("t1_in_ready", 64'(in_ready), 64'd1);
      chk("t1_busy", 64'(busy), 64'd1);
      tuple(8'h00, 4'd3, 4'd1, 4'd2, 16'hFFFF, 1'b0);
      in_valid = 1'b1; wr_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      chk("t1_wr_valid", 64'(wr_valid), 64'd1);
      chk("t1_wr_addr", 64'(wr_addr), 64'd0);
      chk("t1_wr_data", 64'(wr_data), 64'h00312000);
      chk("t1_in_ready_hold", 64'(in_ready), 64'd0);
      @(negedge clk);
      chk("t1_words", 64'(words_written), 64'd1);
      chk("t1_back_accept", 64'(in_ready), 64'd1);
      chk("t1_wr_valid_low", 64'(wr_valid), 64'd0);

      // back-to-back I-type then branch with last
      pulse_reset();
      pulse_start();
      tuple(8'h48, 4'd5, 4'd6, 4'd0, 16'h1234, 1'b0);
      in_valid = 1'b1;
      @(negedge clk);
      chk("t2a_wr_addr", 64'(wr_addr), 64'd0);
      chk("t2a_wr_data", 64'(wr_data), 64'h48561234);
      tuple(8'hC4, 4'd9, 4'd7, 4'd8, 16'hFFFC, 1'b1);
      @(negedge clk);
      chk("t2b_in_ready", 64'(in_ready), 64'd1);
      @(negedge clk);
      in_valid = 1'b0;
      chk("t2b_wr_addr", 64'(wr_addr), 64'd1);
      chk("t2b_wr_data", 64'(wr_data), 64'hC478FFFC);
      @(negedge clk);
      chk("t2_done", 64'(done), 64'd1);
      chk("t2_busy", 64'(busy), 64'd0);
      chk("t2_in_ready", 64'(in_ready), 64'd0);
      chk("t2_wr_valid", 64'(wr_valid), 64'd0);
      chk("t2_words", 64'(words_written), 64'd2);
      @(negedge clk);
      chk("t2_done_held", 64'(done), 64'd1);
      chk("t2_words_held", 64'(words_written), 64'd2);

      // backpressure for five cycles while another tuple is offered
      pulse_start();
      chk("t3_done_cleared", 64'(done), 64'd0);
      chk("t3_words_cleared", 64'(words_written), 64'd0);
      wr_ready = 1'b0;
      tuple(8'h85, 4'hA, 4'hB, 4'h0, 16'hBEEF, 1'b1);
      in_valid = 1'b1;
      @(negedge clk);
      tuple(8'h11, 4'h1, 4'h1, 4'h1, 16'h1111, 1'b0);
      for (int k = 0; k < 5; k++) begin
         chk("t3_bp_wr_valid", 64'(wr_valid), 64'd1);
         chk("t3_bp_wr_addr", 64'(wr_addr), 64'd0);
         chk("t3_bp_wr_data", 64'(wr_data), 64'h85ABBEEF);
         chk("t3_bp_in_ready", 64'(in_ready), 64'd0);
         chk("t3_bp_words", 64'(words_written), 64'd0);
         @(negedge clk);
      end
      wr_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      chk("t3_words", 64'(words_written), 64'd1);
      chk("t3_done", 64'(done), 64'd1);

      // MAX_WORDS=4 instance: six tuples offered, only four written
      pulse_reset();
      @(negedge clk);
      start4 = 1'b1;
      @(negedge clk);
      start4 = 1'b0;
      a = 0; n_wr = 0; prev_rdy = 1'b0;
      tuple(8'h40, 4'd0, 4'd0, 4'd0, 16'd0, 1'b0);
      in_valid = 1'b1; wr_ready = 1'b1;
      for (int c = 0; c < 20; c++) begin
         if (prev_rdy && a < 6) begin
            a++;
            tuple(8'h40, 4'(a), 4'd0, 4'd0, 16'(a), 1'b0);
         end
         if (wr_valid4) begin
            chk("t4_wr_addr", 64'(wr_addr4), 64'(n_wr));
            chk("t4_wr_data", 64'(wr_data4), 64'h40000000 | (64'(n_wr) << 20) | 64'(n_wr));
            n_wr++;
         end
         prev_rdy = in_ready4;
         @(negedge clk);
      end
      in_valid = 1'b0;
      chk("t4_writes", 64'(n_wr), 64'd4);
      chk("t4_accepts", 64'(a), 64'd4);
      chk("t4_done", 64'(done4), 64'd1);
      chk("t4_words", 64'(words_written4), 64'd4);
      chk("t4_last_addr", 64'(wr_addr4), 64'd3);
      start4 = 1'b1;
      @(negedge clk);
      start4 = 1'b0;
      chk("t4_restart_ready", 64'(in_ready4), 64'd1);
      chk("t4_restart_addr", 64'(wr_addr4), 64'd0);
      chk("t4_restart_words", 64'(words_written4), 64'd0);
      chk("t4_restart_done", 64'(done4), 64'd0);
      tuple(8'h00, 4'd3, 4'd1, 4'd2, 16'h0, 1'b0);
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      chk("t4_restart_wr_addr", 64'(wr_addr4), 64'd0);
      chk("t4_restart_wr_data", 64'(wr_data4), 64'h00312000);

      // async reset in HOLD under backpressure
      pulse_reset();
      pulse_start();
      wr_ready = 1'b0;
      tuple(8'h48, 4'd5, 4'd6, 4'd0, 16'h1234, 1'b0);
      in_valid = 1'b1;
      @(negedge clk);
      chk("t5_in_hold", 64'(wr_valid), 64'd1);
      #2;
      reset = 1'b1;
      #1;
      chk_idle_zero("t5_async");
      @(negedge clk);
      reset = 1'b0;
      wr_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("t5_ign_in_ready", 64'(in_ready), 64'd0);
         chk("t5_ign_wr_valid", 64'(wr_valid), 64'd0);
         chk("t5_ign_busy", 64'(busy), 64'd0);
      end
      in_valid = 1'b0;

`ifdef INSTR_ENC_CHECKSUM_EN
      // running XOR of the two accepted words
      pulse_start();
      tuple(8'h00, 4'd3, 4'd1, 4'd2, 16'hFFFF, 1'b0);
      in_valid = 1'b1;
      @(negedge clk);
      tuple(8'h48, 4'd5, 4'd6, 4'd0, 16'h1234, 1'b1);
      @(negedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      chk("cs_done", 64'(done), 64'd1);
      chk("cs_value", 64'(checksum), 64'h48673234);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
